alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, rising-edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have ports: Op  in  4  HI/LO operation code (muldiv_op_t); A  in  32  rs operand; B  in  32  rt operand.
REQ-003 SHALL have port: EX_Stall  in  1  EX stage frozen; no new op accepted while high.
REQ-004 SHALL have ports: HI  out  32  HI register; LO  out  32  LO register; Busy  out  1  multi-cycle op in flight.
REQ-005 SHALL have port: EX_ALU_Stall  out  1  stall request to the hazard controller.

Function
REQ-006 SHALL support Op values NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-007 SHALL accept an op at a rising edge only when Op != NONE, EX_Stall = 0 and Busy = 0; that edge is "edge 0".
REQ-008 SHALL implement FSM states IDLE, MUL, DIV, FIX; transitions only on accepted ops or completion.
REQ-009 MULT/MULTU: IDLE->MUL at edge 0; 64-bit product written {HI,LO} at edge 1; MUL->IDLE at edge 1.
REQ-010 DIV/DIVU: IDLE->DIV at edge 0; one restoring-division iteration per edge 1..32 (5-bit counter 31 down to 0); DIV->FIX after count 0; sign correction and write LO=quotient, HI=remainder at edge 33; FIX->IDLE.
REQ-011 Signed ops SHALL operate on magnitudes; quotient negated if signs differ; remainder takes sign of dividend.
REQ-012 Divide by zero SHALL raise no exception and produce LO=0xFFFFFFFF, HI=A (dividend, sign-corrected as REQ-011 for DIV).
REQ-013 DIV 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000, HI=0x00000000.
REQ-014 MTHI/MTLO SHALL write A to HI/LO at edge 0, single cycle, Busy stays 0.
REQ-015 MFHI/MFLO SHALL cause no state change; HI/LO outputs are the register values, read combinationally by EX.
REQ-016 Busy SHALL be 1 exactly while state != IDLE.
REQ-017 EX_ALU_Stall SHALL be combinational: Busy AND (Op != NONE); deasserts in the cycle after the HI/LO write edge.
REQ-018 Operands SHALL be captured at edge 0; A/B changes during Busy have no effect.
REQ-019 Op held while EX_Stall=1 SHALL be accepted at the first edge with EX_Stall=0 and Busy=0, exactly once.
REQ-020 Undefined Op encodings SHALL be treated as NONE.

Reset
REQ-021 reset SHALL asynchronously force state IDLE, HI=0, LO=0, counter=0, Busy=0, EX_ALU_Stall=0 (Op permitting).
REQ-022 reset during MUL/DIV/FIX SHALL abandon the op with no HI/LO write after reset release.

Configuration
REQ-023 With MULDIV_MADD_EN defined: ops MADD, MADDU, MSUB, MSUBU SHALL be supported using MUL timing, {HI,LO} <= {HI,LO} +/- product (64-bit, wrap-around, no overflow flag).
REQ-024 Without MULDIV_MADD_EN: MADD/MADDU/MSUB/MSUBU encodings SHALL be treated as NONE; no accumulator adder synthesized.

Structure
REQ-025 muldiv_op_t enum, FSM state enum, DIV_ITERATIONS=32 constant SHALL live in the shared processor package.
REQ-026 Divider datapath SHALL be sub-module muldiv_divider (iteration step + sign fix); multiplier and FSM remain in alu_muldiv.

Verification
REQ-027 MULT A=0xFFFFFFFF, B=0x00000002 -> after edge 1 HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-028 DIV A=-7 (0xFFFFFFF9), B=2, then MFLO held on Op -> EX_ALU_Stall=1 for cycles through edge 33, then LO=0xFFFFFFFD, HI=0xFFFFFFFF, stall 0.
REQ-029 DIVU A=100, B=0 -> at edge 33 LO=0xFFFFFFFF, HI=0x00000064; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-030 MTHI A=0x12345678 with EX_Stall=1 for 3 cycles -> HI unchanged until first edge with EX_Stall=0, then HI=0x12345678, Busy never 1.
REQ-031 DIVU issued, reset pulsed at edge 10 -> HI=LO=0, Busy=0 immediately; no later write; next MULTU 3x4 -> LO=12.
REQ-032 (MULDIV_MADD_EN) HI=0, LO=0xFFFFFFFF, MADDU 1x1 -> HI=1, LO=0; without macro same stimulus -> HI/LO unchanged.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared HI/LO unit definitions: op codes, FSM states and the op decoder.
// MULDIV_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package alu_muldiv_pkg;

   localparam int unsigned DIV_ITERATIONS = 32;

   typedef enum logic [3:0] {
      OpNone  = 4'd0,
      OpMult  = 4'd1,
      OpMultu = 4'd2,
      OpDiv   = 4'd3,
      OpDivu  = 4'd4,
      OpMthi  = 4'd5,
      OpMtlo  = 4'd6,
      OpMfhi  = 4'd7,
      OpMflo  = 4'd8,
      OpMadd  = 4'd9,
      OpMaddu = 4'd10,
      OpMsub  = 4'd11,
      OpMsubu = 4'd12
   } muldiv_op_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2,
      StFix  = 2'd3
   } muldiv_state_t;

   // Unknown encodings (and accumulate ops when disabled) collapse to OpNone.
   function automatic muldiv_op_t decode_op(logic [3:0] raw);
      muldiv_op_t op;
      op = OpNone;
      if (raw <= 4'd8) begin
         op = muldiv_op_t'(raw);
      end
`ifdef MULDIV_MADD_EN
      else if (raw <= 4'd12) begin
         op = muldiv_op_t'(raw);
      end
`endif
      return op;
   endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring divider datapath: one quotient bit per step, sign fix applied
// combinationally on the result.
module muldiv_divider (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        step,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [31:0] quo_q, rem_q, dvs_q;
   logic        neg_quo_q, neg_rem_q, zero_q;
   logic [31:0] abs_a, abs_b;
   logic [32:0] rem_sh, diff;

   assign abs_a  = (is_signed && dividend[31]) ? -dividend : dividend;
   assign abs_b  = (is_signed && divisor[31]) ? -divisor : divisor;
   assign rem_sh = {rem_q, quo_q[31]};
   assign diff   = rem_sh - {1'b0, dvs_q};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         zero_q    <= 1'b0;
      end else if (start) begin
         quo_q     <= abs_a;
         rem_q     <= '0;
         dvs_q     <= abs_b;
         neg_quo_q <= is_signed & (dividend[31] ^ divisor[31]);
         neg_rem_q <= is_signed & dividend[31];
         zero_q    <= (divisor == '0);
      end else if (step) begin
         // A borrow out of bit 32 means the trial subtraction failed: restore.
         if (!diff[32]) begin
            rem_q <= diff[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
         end else begin
            rem_q <= rem_sh[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
         end
      end
   end

   assign quotient  = zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
   assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/alu_muldiv.sv
// HI/LO multiply/divide unit: single-cycle multiply, 32-step divide, MTHI/MTLO.
// MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulating into {HI,LO}.
module alu_muldiv
   import alu_muldiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        EX_Stall,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Busy,
   output logic        EX_ALU_Stall
);

   muldiv_op_t    op;
   muldiv_state_t state_q;
   logic [31:0]   hi_q, lo_q, a_q, b_q;
   logic          signed_q, busy_q;
   logic [4:0]    count_q;
   logic          accept, div_start, div_step;
   logic [63:0]   mul_a, mul_b, product, mul_result;
   logic [31:0]   div_quo, div_rem;
`ifdef MULDIV_MADD_EN
   logic          acc_q, sub_q;
`endif

   assign op           = decode_op(Op);
   assign accept       = (op != OpNone) && !EX_Stall && !busy_q;
   assign div_start    = accept && (op == OpDiv || op == OpDivu);
   assign div_step     = (state_q == StDiv);
   assign Busy         = busy_q;
   assign EX_ALU_Stall = busy_q && (op != OpNone);
   assign HI           = hi_q;
   assign LO           = lo_q;

   // Sign-extending to 64 bits lets one unsigned multiplier serve both forms.
   assign mul_a   = {{32{signed_q & a_q[31]}}, a_q};
   assign mul_b   = {{32{signed_q & b_q[31]}}, b_q};
   assign product = mul_a * mul_b;

   always_comb begin
      mul_result = product;
`ifdef MULDIV_MADD_EN
      if (acc_q) begin
         mul_result = sub_q ? ({hi_q, lo_q} - product) : ({hi_q, lo_q} + product);
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         hi_q     <= '0;
         lo_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         signed_q <= 1'b0;
         busy_q   <= 1'b0;
         count_q  <= '0;
`ifdef MULDIV_MADD_EN
         acc_q    <= 1'b0;
         sub_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  case (op)
                     OpMult, OpMultu: begin
                        state_q  <= StMul;
                        busy_q   <= 1'b1;
                        a_q      <= A;
                        b_q      <= B;
                        signed_q <= (op == OpMult);
`ifdef MULDIV_MADD_EN
                        acc_q    <= 1'b0;
                        sub_q    <= 1'b0;
`endif
                     end
`ifdef MULDIV_MADD_EN
                     OpMadd, OpMaddu, OpMsub, OpMsubu: begin
                        state_q  <= StMul;
                        busy_q   <= 1'b1;
                        a_q      <= A;
                        b_q      <= B;
                        signed_q <= (op == OpMadd || op == OpMsub);
                        acc_q    <= 1'b1;
                        sub_q    <= (op == OpMsub || op == OpMsubu);
                     end
`endif
                     OpDiv, OpDivu: begin
                        state_q <= StDiv;
                        busy_q  <= 1'b1;
                        count_q <= 5'(DIV_ITERATIONS - 1);
                     end
                     OpMthi:  hi_q <= A;
                     OpMtlo:  lo_q <= A;
                     default: ;
                  endcase
               end
            end
            StMul: begin
               {hi_q, lo_q} <= mul_result;
               state_q      <= StIdle;
               busy_q       <= 1'b0;
            end
            StDiv: begin
               if (count_q == '0) begin
                  state_q <= StFix;
               end else begin
                  count_q <= count_q - 5'd1;
               end
            end
            StFix: begin
               hi_q    <= div_rem;
               lo_q    <= div_quo;
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   muldiv_divider u_divider (
      .clock     (clock),
      .reset     (reset),
      .start     (div_start),
      .step      (div_step),
      .is_signed (op == OpDiv),
      .dividend  (A),
      .divisor   (B),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv.
module tb_alu_muldiv;
   import alu_muldiv_pkg::*;

   logic        clock, reset, EX_Stall, Busy, EX_ALU_Stall;
   logic [3:0]  Op;
   logic [31:0] A, B, HI, LO;
   int          n_cmp, n_fail;

   alu_muldiv dut (
      .clock        (clock),
      .reset        (reset),
      .Op           (Op),
      .A            (A),
      .B            (B),
      .EX_Stall     (EX_Stall),
      .HI           (HI),
      .LO           (LO),
      .Busy         (Busy),
      .EX_ALU_Stall (EX_ALU_Stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue an op, drop Op after edge 0, wait (bounded) for Busy to fall.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
      Op = op; A = a; B = b;
      tick();
      Op = OpNone;
      cycles = 0;
      while (Busy && cycles < 40) begin
         tick();
         cycles++;
      end
      n_cmp++;
      if (Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", Busy, cycles);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; Op = OpMult; A = 32'd5; B = 32'd6; EX_Stall = 1'b0;
      #3;
      n_cmp++; if (HI !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h required 0", HI); end
      n_cmp++; if (LO !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h required 0", LO); end
      tick();
      n_cmp++; if (Busy !== 1'b0 || EX_ALU_Stall !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: busy=%b stall=%b required 0/0", Busy, EX_ALU_Stall);
      end
      Op = OpNone;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_mult();
      int c;
      Op = OpMult; A = 32'hFFFFFFFF; B = 32'h2;
      tick();
      n_cmp++; if (Busy !== 1'b1 || EX_ALU_Stall !== 1'b1) begin
         n_fail++; $display("FAIL mult_busy: busy=%b stall=%b required 1/1", Busy, EX_ALU_Stall);
      end
      Op = OpNone; A = 32'h0; B = 32'h0;
      #1;
      n_cmp++; if (EX_ALU_Stall !== 1'b0) begin
         n_fail++; $display("FAIL mult_stall_none: got %b required 0", EX_ALU_Stall);
      end
      tick();
      n_cmp++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE || Busy !== 1'b0) begin
         n_fail++; $display("FAIL mult: got %h_%h busy=%b required ffffffff_fffffffe 0", HI, LO, Busy);
      end
      do_op(OpMultu, 32'hFFFFFFFF, 32'h2, c);
      n_cmp++; if (HI !== 32'h1 || LO !== 32'hFFFFFFFE || c != 1) begin
         n_fail++; $display("FAIL multu: got %h_%h lat=%0d required 00000001_fffffffe 1", HI, LO, c);
      end
      do_op(OpMult, 32'hFFFFFFFD, 32'h7, c);
      n_cmp++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin
         n_fail++; $display("FAIL mult_neg: got %h_%h required ffffffff_ffffffeb", HI, LO);
      end
   endtask

   task automatic test_div_stall();
      int n;
      Op = OpDiv; A = 32'hFFFFFFF9; B = 32'd2;
      tick();
      Op = OpMflo; A = 32'hDEADBEEF; B = 32'h0;
      #1;
      n_cmp++; if (EX_ALU_Stall !== 1'b1) begin
         n_fail++; $display("FAIL div_stall_on: got %b required 1", EX_ALU_Stall);
      end
      n = 0;
      while (EX_ALU_Stall && n < 40) begin
         tick();
         n++;
      end
      n_cmp++; if (n != 33) begin n_fail++; $display("FAIL div_stall_len: got %0d required 33", n); end
      n_cmp++; if (LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF || Busy !== 1'b0) begin
         n_fail++; $display("FAIL div_neg: got %h_%h busy=%b required ffffffff_fffffffd 0", HI, LO, Busy);
      end
      Op = OpNone;
      tick();
   endtask

   task automatic test_div_corner();
      int c;
      do_op(OpDivu, 32'd100, 32'd0, c);
      n_cmp++; if (LO !== 32'hFFFFFFFF || HI !== 32'h64 || c != 33) begin
         n_fail++; $display("FAIL divu_zero: got %h_%h lat=%0d required 00000064_ffffffff 33", HI, LO, c);
      end
      do_op(OpDiv, 32'h80000000, 32'hFFFFFFFF, c);
      n_cmp++; if (LO !== 32'h80000000 || HI !== 32'h0) begin
         n_fail++; $display("FAIL div_ovf: got %h_%h required 00000000_80000000", HI, LO);
      end
      do_op(OpDiv, 32'hFFFFFFF9, 32'd0, c);
      n_cmp++; if (LO !== 32'hFFFFFFFF || HI !== 32'hFFFFFFF9) begin
         n_fail++; $display("FAIL div_zero_neg: got %h_%h required fffffff9_ffffffff", HI, LO);
      end
      do_op(OpDiv, 32'd7, 32'hFFFFFFFE, c);
      n_cmp++; if (LO !== 32'hFFFFFFFD || HI !== 32'h1) begin
         n_fail++; $display("FAIL div_negdiv: got %h_%h required 00000001_fffffffd", HI, LO);
      end
      do_op(OpDivu, 32'hFFFFFFFF, 32'd10, c);
      n_cmp++; if (LO !== 32'h19999999 || HI !== 32'h5) begin
         n_fail++; $display("FAIL divu_big: got %h_%h required 00000005_19999999", HI, LO);
      end
   endtask

   task automatic test_mthi_stall();
      logic [31:0] hi0;
      logic        busy_seen;
      hi0 = HI;
      busy_seen = 1'b0;
      Op = OpMthi; A = 32'h12345678; EX_Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         busy_seen |= Busy;
         n_cmp++; if (HI !== hi0) begin
            n_fail++; $display("FAIL mthi_held: got %h required %h", HI, hi0);
         end
      end
      EX_Stall = 1'b0;
      tick();
      busy_seen |= Busy;
      Op = OpNone;
      n_cmp++; if (HI !== 32'h12345678 || busy_seen !== 1'b0) begin
         n_fail++; $display("FAIL mthi: got %h busy_seen=%b required 12345678 0", HI, busy_seen);
      end
      Op = OpMtlo; A = 32'hCAFEF00D;
      tick();
      Op = OpNone;
      n_cmp++; if (LO !== 32'hCAFEF00D || HI !== 32'h12345678 || Busy !== 1'b0) begin
         n_fail++; $display("FAIL mtlo: got %h_%h busy=%b required 12345678_cafef00d 0", HI, LO, Busy);
      end
   endtask

   task automatic test_reset_mid();
      int c;
      Op = OpDivu; A = 32'd1000; B = 32'd3;
      tick();
      Op = OpNone;
      repeat (9) tick();
      @(posedge clock);
      reset = 1'b1;
      #1;
      n_cmp++; if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid: got %h_%h busy=%b required 0_0 0", HI, LO, Busy);
      end
      #5;
      reset = 1'b0;
      repeat (40) tick();
      n_cmp++; if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_nowrite: got %h_%h busy=%b required 0_0 0", HI, LO, Busy);
      end
      do_op(OpMultu, 32'd3, 32'd4, c);
      n_cmp++; if (LO !== 32'd12 || HI !== 32'h0) begin
         n_fail++; $display("FAIL post_reset_mul: got %h_%h required 00000000_0000000c", HI, LO);
      end
   endtask

   task automatic test_madd();
      int c;
      do_op(OpMthi, 32'h0, 32'h0, c);
      do_op(OpMtlo, 32'hFFFFFFFF, 32'h0, c);
      do_op(OpMaddu, 32'd1, 32'd1, c);
`ifdef MULDIV_MADD_EN
      n_cmp++; if (HI !== 32'h1 || LO !== 32'h0 || c != 1) begin
         n_fail++; $display("FAIL maddu: got %h_%h lat=%0d required 00000001_00000000 1", HI, LO, c);
      end
      do_op(OpMsub, 32'd2, 32'hFFFFFFFF, c);
      n_cmp++; if (HI !== 32'h1 || LO !== 32'h2) begin
         n_fail++; $display("FAIL msub: got %h_%h required 00000001_00000002", HI, LO);
      end
`else
      n_cmp++; if (HI !== 32'h0 || LO !== 32'hFFFFFFFF || c != 0) begin
         n_fail++; $display("FAIL maddu_off: got %h_%h lat=%0d required 00000000_ffffffff 0", HI, LO, c);
      end
`endif
      Op = 4'd15; A = 32'h5555AAAA;
      tick();
      n_cmp++; if (Busy !== 1'b0 || EX_ALU_Stall !== 1'b0) begin
         n_fail++; $display("FAIL undef_op: busy=%b stall=%b required 0/0", Busy, EX_ALU_Stall);
      end
      Op = OpNone;
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      test_reset();
      test_mult();
      test_div_stall();
      test_div_corner();
      test_mthi_stall();
      test_reset_mid();
      test_madd();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
